// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined RADIX-ary mux tree selecting one of RADIX**LEVELS channels, with
// valid/ready on both sides. Define MUX_TREE_SCAN_EN to add scan_mode and a channel scan counter.
module mux_tree_pipe #(
  parameter int unsigned RADIX  = 8,
  parameter int unsigned LEVELS = 2,
  parameter int unsigned DATA_W = 1,
  localparam int unsigned N      = RADIX ** LEVELS,
  localparam int unsigned RSEL_W = $clog2(RADIX),
  localparam int unsigned SEL_W  = LEVELS * RSEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef MUX_TREE_SCAN_EN
  input  logic                scan_mode,
`endif
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  if (RADIX < 2 || (RADIX & (RADIX - 1)) != 0 || LEVELS < 1) begin : gen_bad_params
    $error("mux_tree_pipe: RADIX must be a power of two >= 2 and LEVELS >= 1");
  end

  logic [SEL_W-1:0]  eff_sel;
  logic [LEVELS:0]   ready;
  logic [LEVELS-1:0] stage_v;

`ifdef MUX_TREE_SCAN_EN
  logic [SEL_W-1:0] scan_idx_q, scan_idx_d;

  // N is a power of two, so the natural wrap of the counter covers N-1 -> 0.
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_mode && in_valid && in_ready) begin
      scan_idx_d = scan_idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx_q <= '0;
    end else begin
      scan_idx_q <= scan_idx_d;
    end
  end

  assign eff_sel = scan_mode ? scan_idx_q : in_sel;
`else
  assign eff_sel = in_sel;
`endif

  // A stage can take a new beat if it is empty or its current beat moves on this cycle.
  always_comb begin
    ready         = '0;
    ready[LEVELS] = out_ready;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      ready[k] = !stage_v[k] || ready[k+1];
    end
  end

  assign in_ready = ready[0];

  for (genvar k = 0; k < LEVELS; k++) begin : gen_stage
    localparam int unsigned Groups = RADIX ** (LEVELS - 1 - k);
    localparam int unsigned InW    = Groups * RADIX * DATA_W;

    logic [Groups*DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic                     v_q, v_d;
    logic [InW-1:0]           up_data;
    logic [SEL_W-1:0]         up_sel;
    logic                     up_valid;
    logic [RSEL_W-1:0]        slice;

    if (k == 0) begin : gen_src
      assign up_data  = in_data;
      assign up_sel   = eff_sel;
      assign up_valid = in_valid;
    end else begin : gen_src
      assign up_data  = gen_stage[k-1].data_q;
      assign up_sel   = gen_stage[k-1].sel_q;
      assign up_valid = gen_stage[k-1].v_q;
    end

    // Payload only updates on a real beat so bubbles never pull in undriven inputs.
    always_comb begin
      slice  = up_sel[k*RSEL_W +: RSEL_W];
      data_d = data_q;
      sel_d  = sel_q;
      v_d    = v_q;
      if (ready[k]) begin
        v_d = up_valid;
        if (up_valid) begin
          sel_d = up_sel;
          for (int unsigned g = 0; g < Groups; g++) begin
            data_d[g*DATA_W +: DATA_W] = up_data[(g*RADIX + 32'(slice))*DATA_W +: DATA_W];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
        sel_q  <= '0;
        v_q    <= 1'b0;
      end else begin
        data_q <= data_d;
        sel_q  <= sel_d;
        v_q    <= v_d;
      end
    end

    assign stage_v[k] = v_q;
  end

  assign out_valid = gen_stage[LEVELS-1].v_q;
  assign out_data  = gen_stage[LEVELS-1].data_q;
  assign out_sel   = gen_stage[LEVELS-1].sel_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: vector table, hand sequences and a random stream
// scored against a channel-index reference queue.
module tb_mux_tree_pipe;
  localparam int unsigned DataW = 1;
  localparam int unsigned NCh   = 64;
  localparam int unsigned SelW  = 6;
  localparam logic [63:0] Pat   = 64'hA5A5_0F0F_3C3C_FF00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCh*DataW-1:0] in_data;
  logic [SelW-1:0]      in_sel;
  logic                 in_valid, in_ready;
  logic [DataW-1:0]     out_data;
  logic [SelW-1:0]      out_sel;
  logic                 out_valid, out_ready;

  logic [255:0] in_data5;
  logic [5:0]   in_sel5, out_sel5;
  logic [3:0]   out_data5;
  logic         in_valid5, in_ready5, out_valid5, out_ready5;

`ifdef MUX_TREE_SCAN_EN
  logic       scan_mode;
  logic [5:0] scan_model;
`endif

  mux_tree_pipe #(.RADIX(8), .LEVELS(2), .DATA_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_TREE_SCAN_EN
    .scan_mode (scan_mode),
`endif
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_tree_pipe #(.RADIX(4), .LEVELS(3), .DATA_W(4)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_TREE_SCAN_EN
    .scan_mode (1'b0),
`endif
    .in_data   (in_data5),
    .in_sel    (in_sel5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_sel   (out_sel5),
    .out_valid (out_valid5),
    .out_ready (out_ready5)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: every accepted beat is channel in_data[sel], delivered in acceptance order.
  typedef struct packed {
    logic [DataW-1:0] d;
    logic [SelW-1:0]  s;
  } beat_t;

  beat_t            exp_q[$];
  int               rx_count = 0;
  logic             hold_pend = 1'b0;
  logic [DataW-1:0] hold_d;
  logic [SelW-1:0]  hold_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pend = 1'b0;
`ifdef MUX_TREE_SCAN_EN
      scan_model = '0;
`endif
    end else begin : mon
      beat_t e;
      logic [SelW-1:0] s;
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_sel", out_sel, hold_s);
      end
      hold_pend = out_valid && !out_ready;
      hold_d    = out_data;
      hold_s    = out_sel;
      if (out_valid && out_ready) begin
        rx_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sel %0d expected no beat", out_sel);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_sel", out_sel, e.s);
        end
      end
      if (in_valid && in_ready) begin
`ifdef MUX_TREE_SCAN_EN
        s = scan_mode ? scan_model : in_sel;
        if (scan_mode) scan_model = scan_model + 6'd1;
`else
        s = in_sel;
`endif
        e.s = s;
        e.d = in_data[s*DataW +: DataW];
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 0);
  endtask

  typedef struct {
    logic [63:0] data;
    logic [5:0]  sel;
    logic        exp_d;
  } vec_t;

  task automatic beat5(input logic [5:0] s, input logic [3:0] exp);
    in_sel5   = s;
    in_valid5 = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", in_ready5, 1);
    tick();
    in_valid5 = 1'b0;
    @(negedge clk);
    chk("t5_lat1", out_valid5, 0);
    tick();
    @(negedge clk);
    chk("t5_lat2", out_valid5, 0);
    tick();
    @(negedge clk);
    chk("t5_valid", out_valid5, 1);
    chk("t5_data", out_data5, exp);
    chk("t5_sel", out_sel5, s);
    tick();
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   idx, c, rx0;
    logic acc, saw_stall;

    vecs[0] = '{64'd1 << 37, 6'd37, 1'b1};
    vecs[1] = '{64'd1 << 37, 6'd36, 1'b0};
    vecs[2] = '{Pat, 6'd8, 1'b1};
    vecs[3] = '{Pat, 6'd7, 1'b0};
    vecs[4] = '{Pat, 6'd63, 1'b1};
    vecs[5] = '{Pat, 6'd62, 1'b0};
    vecs[6] = '{Pat, 6'd18, 1'b1};
    vecs[7] = '{~(64'd1 << 9), 6'd9, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b1;
    in_valid5 = 1'b0; in_sel5 = '0; out_ready5 = 1'b1;
`ifdef MUX_TREE_SCAN_EN
    scan_mode = 1'b0;
`endif
    for (int i = 0; i < 64; i++) in_data5[i*4 +: 4] = 4'((i * 7 + 3) & 15);
    in_data5[63*4 +: 4] = 4'hC;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;

    // Single beats: out_valid exactly two cycles after acceptance.
    for (int i = 0; i < 8; i++) begin
      in_data = vecs[i].data; in_sel = vecs[i].sel; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat1", out_valid, 0);
      tick();
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vecs[i].exp_d);
      chk("vec_sel", out_sel, vecs[i].sel);
      tick();
    end

    // Back-to-back stream, no backpressure.
    rx0 = rx_count;
    in_data = Pat;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_sel = 6'(i);
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    drain("stream_drain");
    chk("stream_count", 64'(rx_count - rx0), 64);

    // Same stream with the sink stalled for cycles 5..9.
    rx0 = rx_count; idx = 0; c = 0; saw_stall = 1'b0;
    while (idx < 64 && c < 300) begin
      in_valid = 1'b1; in_sel = 6'(idx);
      out_ready = !(c >= 5 && c <= 9);
      @(negedge clk);
      acc = in_ready;
      if (!in_ready) saw_stall = 1'b1;
      tick();
      if (acc) idx++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_all_accepted", 64'(idx), 64);
    chk("bp_stall_seen", saw_stall, 1);
    drain("bp_drain");
    chk("bp_count", 64'(rx_count - rx0), 64);

    // Reset with two beats in flight.
    in_data = '1; in_sel = 6'd11; in_valid = 1'b1;
    tick();
    in_sel = 6'd12;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_out_sel", out_sel, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (5) tick();

    // Random traffic with random sink backpressure.
    rx0 = rx_count;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 6'($urandom_range(0, 63));
      in_data   = {$urandom(), $urandom()};
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand_drain");

    // Three-level radix-4 tree with 4-bit channels.
    beat5(6'd63, 4'hC);
    beat5(6'd0, in_data5[0 +: 4]);
    beat5(6'd21, in_data5[21*4 +: 4]);
    beat5(6'd42, in_data5[42*4 +: 4]);

`ifdef MUX_TREE_SCAN_EN
    scan_mode = 1'b1; in_data = {$urandom(), $urandom()};
    for (int i = 0; i < 66; i++) begin
      in_valid = 1'b1; in_sel = 6'($urandom_range(0, 63));
      @(negedge clk);
      chk("scan_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0; scan_mode = 1'b0;
    drain("scan_drain");
    in_sel = 6'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("scan_off_sel", out_sel, 5);
    drain("scan_off_drain");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
